sr_multicycle_shifter: RTL



---
 rtl/sr_multicycle_shifter.sv | 105 ++++++++++
 1 files changed

// File: rtl/sr_multicycle_shifter.sv
// Sequential 32-bit right shifter (srl/sra), one barrel stage per clock: 16, 8, 4, 2, 1.
// Latency: fixed 5 cycles from accepted start to the data_resultRDY pulse, for any amount.
// Backpressure: busy is high while shifting and ctrl_start is ignored then; a start is taken in IDLE or in the DONE cycle.
//
// Ports:
//   clock          in   1   rising-edge clock
//   reset          in   1   synchronous, active-high; discards any in-flight shift
//   ctrl_start     in   1   request, accepted when not busy
//   data_operandA  in  32   value to shift, captured on accept
//   ctrl_shiftamt  in   5   shift distance 0-31, captured on accept
//   ctrl_arith     in   1   1 = sign fill (sra), 0 = zero fill (srl), captured on accept
//   data_result    out 32   result register, changes only on completion or reset
//   data_resultRDY out  1   one-cycle pulse marking a new result
//   busy           out  1   high while a shift is in progress
module sr_multicycle_shifter (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctrl_start,
   input  logic [31:0] data_operandA,
   input  logic [4:0]  ctrl_shiftamt,
   input  logic        ctrl_arith,
   output logic [31:0] data_result,
   output logic        data_resultRDY,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_work;
   logic [4:0]  r_amt;
   logic        r_arith;
   logic [2:0]  r_cnt;

   logic        w_fill;
   logic [31:0] w_stage_out;

   // The fill bit is the live work[31]; for sra every stage re-fills with
   // the sign, so work[31] stays equal to the original sign throughout.
   always_comb begin
      w_fill      = r_arith & r_work[31];
      w_stage_out = r_work;
      case (r_cnt)
         3'd4: if (r_amt[4]) w_stage_out = {{16{w_fill}}, r_work[31:16]};
         3'd3: if (r_amt[3]) w_stage_out = {{8{w_fill}},  r_work[31:8]};
         3'd2: if (r_amt[2]) w_stage_out = {{4{w_fill}},  r_work[31:4]};
         3'd1: if (r_amt[1]) w_stage_out = {{2{w_fill}},  r_work[31:2]};
         3'd0: if (r_amt[0]) w_stage_out = {w_fill,       r_work[31:1]};
         default: w_stage_out = r_work;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_work         <= 32'd0;
         r_amt          <= 5'd0;
         r_arith        <= 1'b0;
         r_cnt          <= 3'd0;
         data_result    <= 32'd0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else begin
         case (r_state)
            // DONE behaves like IDLE for acceptance, which gives back-to-back
            // operation without an extra idle cycle.
            S_IDLE, S_DONE: begin
               data_resultRDY <= 1'b0;
               if (ctrl_start) begin
                  r_work  <= data_operandA;
                  r_amt   <= ctrl_shiftamt;
                  r_arith <= ctrl_arith;
                  r_cnt   <= 3'd4;
                  r_state <= S_SHIFT;
                  busy    <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
               end
            end
            S_SHIFT: begin
               r_work <= w_stage_out;
               if (r_cnt == 3'd0) begin
                  data_result    <= w_stage_out;
                  data_resultRDY <= 1'b1;
                  busy           <= 1'b0;
                  r_state        <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            default: begin
               r_state        <= S_IDLE;
               data_resultRDY <= 1'b0;
               busy           <= 1'b0;
            end
         endcase
      end
   end

endmodule
